calc_core_param: RTL and testbench

- Parametrised successor to the single-digit keypad calculator FSM.
- Decodes the 8-bit row/column keypad code with press-edge detection and supports multi-digit operands of configurable width.
- Chains operations left-to-right and runs division on a multi-cycle sequential divider.
- Reports overflow, underflow and divide-by-zero through a sticky error state.
- Sits between the keypad scanner and the display driver.

---
 rtl/calc_pkg.sv | 73 +++++++
 rtl/calc_divider.sv | 65 ++++++
 rtl/calc_core_param.sv | 201 ++++++++++++++++++++
 tb/tb_calc_core_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types, key codes and keypad decoding for the parametrised calculator.
// Key code layout: [7:4] = column 0..3, [3:0] = row 4..7.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ENTB,
    ST_EXEC,
    ST_RES,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_e;

  localparam logic [7:0] KEY_C   = 8'h04;
  localparam logic [7:0] KEY_0   = 8'h14;
  localparam logic [7:0] KEY_EQ  = 8'h24;
  localparam logic [7:0] KEY_DIV = 8'h34;
  localparam logic [7:0] KEY_1   = 8'h05;
  localparam logic [7:0] KEY_2   = 8'h15;
  localparam logic [7:0] KEY_3   = 8'h25;
  localparam logic [7:0] KEY_MUL = 8'h35;
  localparam logic [7:0] KEY_4   = 8'h06;
  localparam logic [7:0] KEY_5   = 8'h16;
  localparam logic [7:0] KEY_6   = 8'h26;
  localparam logic [7:0] KEY_SUB = 8'h36;
  localparam logic [7:0] KEY_7   = 8'h07;
  localparam logic [7:0] KEY_8   = 8'h17;
  localparam logic [7:0] KEY_9   = 8'h27;
  localparam logic [7:0] KEY_ADD = 8'h37;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
    logic       is_op;
    op_e        op;
    logic       is_eq;
    logic       is_clr;
  } key_t;

  // Any code outside the 16 listed keys (including 0) decodes to all-zero.
  function automatic key_t decode_key(input logic [7:0] code);
    key_t k;
    k = '0;
    case (code)
      KEY_C:   k.is_clr = 1'b1;
      KEY_EQ:  k.is_eq  = 1'b1;
      KEY_ADD: begin k.is_op = 1'b1; k.op = OP_ADD; end
      KEY_SUB: begin k.is_op = 1'b1; k.op = OP_SUB; end
      KEY_MUL: begin k.is_op = 1'b1; k.op = OP_MUL; end
      KEY_DIV: begin k.is_op = 1'b1; k.op = OP_DIV; end
      KEY_0:   begin k.is_digit = 1'b1; k.digit = 4'd0; end
      KEY_1:   begin k.is_digit = 1'b1; k.digit = 4'd1; end
      KEY_2:   begin k.is_digit = 1'b1; k.digit = 4'd2; end
      KEY_3:   begin k.is_digit = 1'b1; k.digit = 4'd3; end
      KEY_4:   begin k.is_digit = 1'b1; k.digit = 4'd4; end
      KEY_5:   begin k.is_digit = 1'b1; k.digit = 4'd5; end
      KEY_6:   begin k.is_digit = 1'b1; k.digit = 4'd6; end
      KEY_7:   begin k.is_digit = 1'b1; k.digit = 4'd7; end
      KEY_8:   begin k.is_digit = 1'b1; k.digit = 4'd8; end
      KEY_9:   begin k.is_digit = 1'b1; k.digit = 4'd9; end
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/calc_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles per divide.
// done stays high until the cycle after it is first seen, then the unit idles.
module calc_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             active_reg;

  logic [WIDTH:0]   partial;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Partial remainder is always below 2*divisor, so a successful subtract fits in WIDTH bits.
  assign partial = {rem_reg, quo_reg[WIDTH-1]};
  assign fits    = partial >= {1'b0, dvs_reg};
  assign diff    = WIDTH'(partial - {1'b0, dvs_reg});

  assign quotient = quo_reg;
  assign done     = active_reg && (cnt_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (abort) begin
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      rem_reg    <= '0;
      quo_reg    <= dividend;
      dvs_reg    <= divisor;
      cnt_reg    <= CW'(WIDTH);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (cnt_reg != '0) begin
        rem_reg <= fits ? diff : partial[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], fits};
        cnt_reg <= cnt_reg - CW'(1);
      end else begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// Keypad calculator core: multi-digit unsigned operands, left-to-right chaining,
// sequential division and a sticky error state cleared only by C.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       button,
  output logic [WIDTH-1:0] display,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WIDTH+3:0] TEN = (WIDTH + 4)'(10);

  state_e           state_reg;
  op_e              op_reg;
  op_e              next_op_reg;
  logic             trig_eq_reg;
  logic [7:0]       btn_prev_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    cnt_a_reg;
  logic [CW-1:0]    cnt_b_reg;

  key_t             key;
  logic             press;
  logic [WIDTH-1:0] digit_w;
  logic [WIDTH+3:0] a_app;
  logic [WIDTH+3:0] b_app;
  logic             a_fits;
  logic             b_fits;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_fault;
  logic               exec_done;

  logic             div_start;
  logic             div_abort;
  logic [WIDTH-1:0] div_quotient;
  logic             div_done;

  assign key     = decode_key(button);
  assign press   = (btn_prev_reg == 8'h00) &&
                   (key.is_digit || key.is_op || key.is_eq || key.is_clr);
  assign digit_w = {{(WIDTH-4){1'b0}}, key.digit};

  // Widened append so an entry that would exceed the operand range is detected and dropped.
  assign a_app  = {4'b0, a_reg} * TEN + {4'b0, digit_w};
  assign b_app  = {4'b0, b_reg} * TEN + {4'b0, digit_w};
  assign a_fits = (a_app[WIDTH+3:WIDTH] == 4'd0) && (cnt_a_reg < CW'(MAX_DIGITS));
  assign b_fits = (b_app[WIDTH+3:WIDTH] == 4'd0) && (cnt_b_reg < CW'(MAX_DIGITS));

  assign sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};

  always_comb begin
    alu_res   = '0;
    alu_fault = 1'b0;
    case (op_reg)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];   alu_fault = sum[WIDTH];               end
      OP_SUB: begin alu_res = a_reg - b_reg;    alu_fault = (b_reg > a_reg);          end
      OP_MUL: begin alu_res = prod[WIDTH-1:0];  alu_fault = |prod[2*WIDTH-1:WIDTH];   end
      default: begin alu_res = div_quotient;    alu_fault = (b_reg == '0);            end
    endcase
  end

  // Division by zero resolves in one cycle without ever launching the divider.
  assign exec_done = (op_reg != OP_DIV) || div_done || (b_reg == '0);
  assign div_start = press && (state_reg == ST_ENTB) && (key.is_op || key.is_eq) &&
                     (op_reg == OP_DIV) && (b_reg != '0);
  assign div_abort = press && key.is_clr;

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (a_reg),
    .divisor  (b_reg),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_ADD;
      next_op_reg  <= OP_ADD;
      trig_eq_reg  <= 1'b0;
      btn_prev_reg <= 8'h00;
      a_reg        <= '0;
      b_reg        <= '0;
      cnt_a_reg    <= '0;
      cnt_b_reg    <= '0;
      display      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      btn_prev_reg <= button;
      result_valid <= 1'b0;
      if (press && key.is_clr) begin
        state_reg   <= ST_IDLE;
        op_reg      <= OP_ADD;
        next_op_reg <= OP_ADD;
        trig_eq_reg <= 1'b0;
        a_reg       <= '0;
        b_reg       <= '0;
        cnt_a_reg   <= '0;
        cnt_b_reg   <= '0;
        display     <= '0;
        result      <= '0;
        busy        <= 1'b0;
        error       <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_OP: if (press) begin
            if (key.is_digit && state_reg == ST_IDLE) begin
              if (a_fits) begin
                a_reg     <= a_app[WIDTH-1:0];
                cnt_a_reg <= cnt_a_reg + CW'(1);
                display   <= a_app[WIDTH-1:0];
              end
            end else if (key.is_digit) begin
              b_reg     <= digit_w;
              cnt_b_reg <= CW'(1);
              display   <= digit_w;
              state_reg <= ST_ENTB;
            end else if (key.is_op) begin
              op_reg    <= key.op;
              state_reg <= ST_OP;
            end else if (key.is_eq) begin
              result       <= a_reg;
              result_valid <= 1'b1;
              display      <= a_reg;
              state_reg    <= ST_RES;
            end
          end
          ST_ENTB: if (press) begin
            if (key.is_digit) begin
              if (b_fits) begin
                b_reg     <= b_app[WIDTH-1:0];
                cnt_b_reg <= cnt_b_reg + CW'(1);
                display   <= b_app[WIDTH-1:0];
              end
            end else if (key.is_op || key.is_eq) begin
              next_op_reg <= key.op;
              trig_eq_reg <= key.is_eq;
              busy        <= 1'b1;
              state_reg   <= ST_EXEC;
            end
          end
          ST_EXEC: if (exec_done) begin
            busy <= 1'b0;
            if (alu_fault) begin
              error     <= 1'b1;
              display   <= '0;
              state_reg <= ST_ERR;
            end else if (trig_eq_reg) begin
              result       <= alu_res;
              result_valid <= 1'b1;
              display      <= alu_res;
              state_reg    <= ST_RES;
            end else begin
              a_reg     <= alu_res;
              op_reg    <= next_op_reg;
              b_reg     <= '0;
              cnt_b_reg <= '0;
              display   <= alu_res;
              state_reg <= ST_OP;
            end
          end
          ST_RES: if (press) begin
            if (key.is_op) begin
              a_reg     <= result;
              op_reg    <= key.op;
              state_reg <= ST_OP;
            end else if (key.is_digit) begin
              a_reg     <= digit_w;
              cnt_a_reg <= CW'(1);
              display   <= digit_w;
              state_reg <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
// Self-checking bench: directed keypad scenarios plus random key streams compared
// against an arithmetic model of the calculator's behaviour.
module tb_calc_core_param;

  localparam int WIDTH = 16;
  localparam int MAXV  = 65535;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       button;
  logic [WIDTH-1:0] display;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             busy;
  logic             error;

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Model state: mode 0 entering A, 1 operator pending, 2 entering B, 4 showing result, 5 error
  int m_a, m_b, m_ca, m_cb, m_op, m_mode, m_disp, m_res, m_err, m_pulses;

  calc_core_param #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button       (button),
    .display      (display),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .error        (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (result_valid === 1'b1) pulse_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Keys: 0..9 digits, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 'C'
  function automatic logic [7:0] code_of(input int k);
    int col, row;
    if (k == 0)       begin col = 1; row = 4; end
    else if (k <= 9)  begin col = (k - 1) % 3; row = 5 + (k - 1) / 3; end
    else if (k == 10) begin col = 3; row = 7; end
    else if (k == 11) begin col = 3; row = 6; end
    else if (k == 12) begin col = 3; row = 5; end
    else if (k == 13) begin col = 3; row = 4; end
    else if (k == 14) begin col = 2; row = 4; end
    else              begin col = 0; row = 4; end
    return {4'(col), 4'(row)};
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_op = 10; m_mode = 0;
    m_disp = 0; m_res = 0; m_err = 0;
  endtask

  task automatic calc(input int op, input longint a, input longint b, output bit ok, output longint r);
    ok = 1'b1; r = 0;
    case (op)
      10: begin r = a + b; ok = (r <= MAXV); end
      11: begin r = a - b; ok = (b <= a); end
      12: begin r = a * b; ok = (r <= MAXV); end
      default: begin ok = (b != 0); r = ok ? a / b : 0; end
    endcase
  endtask

  task automatic model_key(input int k, output bit ex, output int cyc, output bit rv);
    bit is_d, is_op, is_eq, ok;
    longint r;
    ex = 1'b0; cyc = 0; rv = 1'b0;
    is_d = (k <= 9); is_op = (k >= 10 && k <= 13); is_eq = (k == 14);
    if (k == 15) model_clear();
    else if (m_mode == 0 || m_mode == 1) begin
      if (is_d && m_mode == 0) begin
        if (m_ca < 4 && m_a * 10 + k <= MAXV) begin m_a = m_a * 10 + k; m_ca++; m_disp = m_a; end
      end else if (is_d) begin
        m_b = k; m_cb = 1; m_disp = k; m_mode = 2;
      end else if (is_op) begin
        m_op = k; m_mode = 1;
      end else if (is_eq) begin
        m_res = m_a; m_pulses++; m_disp = m_a; m_mode = 4;
      end
    end else if (m_mode == 2) begin
      if (is_d) begin
        if (m_cb < 4 && m_b * 10 + k <= MAXV) begin m_b = m_b * 10 + k; m_cb++; m_disp = m_b; end
      end else begin
        ex = 1'b1;
        cyc = (m_op == 13 && m_b != 0) ? WIDTH + 1 : 1;
        calc(m_op, m_a, m_b, ok, r);
        if (!ok) begin m_mode = 5; m_err = 1; m_disp = 0; end
        else if (is_eq) begin m_res = int'(r); m_pulses++; m_disp = int'(r); m_mode = 4; rv = 1'b1; end
        else begin m_a = int'(r); m_op = k; m_disp = int'(r); m_mode = 1; end
      end
    end else if (m_mode == 4) begin
      if (is_op) begin m_a = m_res; m_op = k; m_mode = 1; end
      else if (is_d) begin m_a = k; m_ca = 1; m_disp = k; m_mode = 0; end
    end
  endtask

  task automatic raw_press(input logic [7:0] code);
    @(negedge clk); button = code;
    @(negedge clk); button = 8'h00;
  endtask

  task automatic check_outputs();
    chk("display", display, m_disp);
    chk("error", error, m_err);
    chk("result", result, m_res);
    chk("pulses", pulse_cnt, m_pulses);
  endtask

  task automatic key(input int k);
    bit ex, rv;
    int cyc, n;
    raw_press(code_of(k));
    model_key(k, ex, cyc, rv);
    chk("busy_after_key", busy, ex);
    if (ex) begin
      n = 0;
      while (busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
      chk("exec_latency", n, cyc);
      chk("rv_at_done", result_valid, rv);
    end
    @(negedge clk);
    check_outputs();
    $display("key %0d: display=%0d result=%0d error=%0d busy=%0d", k, display, result, error, busy);
  endtask

  task automatic keys(input int seq[$]);
    foreach (seq[i]) key(seq[i]);
  endtask

  initial begin
    bit ex, rv;
    int cyc, k;
    button = 8'h00;
    rst_n  = 1'b0;
    m_pulses = 0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_display", display, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;

    // C 5 + 3 =
    keys('{15, 5, 10, 3, 14});
    chk("tp_add_result", result, 8);

    // Invalid codes and key changes without release are ignored
    key(15);
    raw_press(8'h84);
    raw_press(8'h1C);
    raw_press(8'h10);
    @(negedge clk);
    chk("invalid_ignored", display, 0);
    @(negedge clk); button = code_of(1);
    @(negedge clk); button = code_of(3);
    @(negedge clk); button = 8'h00;
    @(negedge clk);
    model_key(1, ex, cyc, rv);
    chk("no_rollover", display, 1);

    // 123 * 45 with key 2 held for five cycles
    key(15); key(1);
    @(negedge clk); button = code_of(2);
    repeat (5) @(negedge clk);
    button = 8'h00;
    @(negedge clk);
    model_key(2, ex, cyc, rv);
    chk("held_key", display, 12);
    keys('{3, 12, 4, 5, 14});
    chk("tp_mul_result", result, 5535);
    keys('{15, 1, 2, 3, 4, 5});
    chk("fifth_digit", display, 1234);

    // Chained 5 - 3 + 2 =
    keys('{15, 5, 11, 3, 10});
    chk("chain_display", display, 2);
    keys('{2, 14});
    chk("chain_result", result, 4);

    // Division then reuse of result
    keys('{15, 6, 13, 3, 14});
    chk("div_result", result, 2);
    keys('{12, 8, 14});
    chk("reuse_result", result, 16);

    // Error cases
    keys('{15, 7, 13, 0, 14});
    chk("div0_error", error, 1);
    key(5);
    chk("err_digit_ignored", display, 0);
    key(15);
    chk("clr_error", error, 0);
    keys('{3, 11, 5, 14});
    chk("underflow_error", error, 1);
    keys('{15, 9, 9, 9, 9, 12, 9, 9, 9, 9, 14});
    chk("overflow_error", error, 1);
    key(15);
    chk("clr_display", display, 0);

    // C while the divider is running
    keys('{9, 13, 3});
    raw_press(code_of(14));
    repeat (3) @(negedge clk);
    chk("div_busy", busy, 1);
    key(15);
    repeat (20) @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_pulse", pulse_cnt, m_pulses);
    key(4);

    // Asynchronous reset mid-entry
    keys('{15, 4, 10, 4, 14, 1, 2});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_display", display, 0);
    chk("arst_result", result, 0);
    chk("arst_busy", busy, 0);
    chk("arst_error", error, 0);
    @(negedge clk); rst_n = 1'b1;
    model_clear();

    // Random key streams
    for (int i = 0; i < 120; i++) begin
      k = (m_mode == 5 || $urandom_range(0, 15) == 0) ? 15 : int'($urandom_range(0, 14));
      key(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
